// File: rtl/lf_tick_rx_pkg.sv
// Shared constants for the slow-clock receiver: FSM encodings and default sizing.
package lf_tick_rx_pkg;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  localparam int          DEF_SYNC_STAGES = 2;
  localparam int          DEF_PERIOD_W    = 24;
  localparam int unsigned DEF_TIMEOUT     = 24'd8000000;

endpackage

// File: rtl/lf_tick_rx_sync_edge_det.sv
// Synchronizer chain for the slow clock plus a warm-up gated edge detector.
// rise is a combinational strobe one cycle ahead of the registered tick, so
// the top can update its state on the same edge that raises tick.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic tick,
  output logic tick_fall,
  output logic warm_done
);

  localparam logic [2:0] WARM_CYC = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [2:0]             warm_q;
  logic                   synced;
  logic                   fall;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_CYC);
  // Edges are ignored until the chain and prev_q hold real samples, so a
  // level present at reset release never looks like an edge.
  assign rise      = warm_done & synced & ~prev_q;
  assign fall      = warm_done & ~synced & prev_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Previous synced sample; tracks during warm-up too.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= synced;
  end

  // Count warm-up cycles after reset release, then saturate.
  always_ff @(posedge clk) begin
    if (rst)             warm_q <= '0;
    else if (!warm_done) warm_q <= warm_q + 3'd1;
  end

  // Register the edge strobes into the one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      tick      <= rise;
      tick_fall <= fall;
    end
  end

endmodule

// File: rtl/lf_tick_rx.sv
// Slow-clock receiver: re-times clk_LF into clk, emits tick/tick_fall enables,
// measures the rise-to-rise period and flags a stalled divider.
// Pulse semantics: tick and tick_fall are single-cycle enables with no
// back-pressure; period, period_valid, tick_cnt and state change on the same
// edge that raises tick, so consumers can sample them alongside tick.
module lf_tick_rx
  import lf_tick_rx_pkg::*;
#(
  parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int          PERIOD_W    = DEF_PERIOD_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                btnC,
  input  logic                clk_LF,
  output logic                tick,
  output logic                tick_fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic [7:0]          tick_cnt,
  output logic [1:0]          state
);

  localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT);

  logic                rise;
  logic                warm_done;
  logic [PERIOD_W-1:0] cnt;
  logic [1:0]          state_q;
  logic [1:0]          state_nxt;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (btnC),
    .din      (clk_LF),
    .rise     (rise),
    .tick     (tick),
    .tick_fall(tick_fall),
    .warm_done(warm_done)
  );

  // Cycles since the last tick: 1 in the tick cycle, saturating at the timeout.
  always_ff @(posedge clk) begin
    if (btnC)                         cnt <= '0;
    else if (rise)                    cnt <= PERIOD_W'(1);
    else if (warm_done && cnt != TMO) cnt <= cnt + PERIOD_W'(1);
  end

  // Next-state decode; an edge in the timeout cycle beats the stall.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_INIT:   if (rise) state_nxt = ST_ARMED;  else if (cnt == TMO) state_nxt = ST_STALL;
      ST_ARMED:  if (rise) state_nxt = ST_LOCKED; else if (cnt == TMO) state_nxt = ST_STALL;
      ST_LOCKED: if (rise) state_nxt = ST_LOCKED; else if (cnt == TMO) state_nxt = ST_STALL;
      default:   if (rise) state_nxt = ST_ARMED;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (btnC) state_q <= ST_INIT;
    else      state_q <= state_nxt;
  end

  // Capture the period only when a previous rise gave a valid start point.
  always_ff @(posedge clk) begin
    if (btnC)
      period <= '0;
    else if (rise && (state_q == ST_ARMED || state_q == ST_LOCKED))
      period <= cnt;
  end

  // Free-running tick counter, wraps silently.
  always_ff @(posedge clk) begin
    if (btnC)      tick_cnt <= '0;
    else if (rise) tick_cnt <= tick_cnt + 8'd1;
  end

  assign state        = state_q;
  assign period_valid = (state_q == ST_LOCKED);
  assign stalled      = (state_q == ST_STALL);

endmodule

// File: tb/tb_lf_tick_rx.sv
// Directed bench for lf_tick_rx (SYNC_STAGES=2, PERIOD_W=8, TIMEOUT=100).
// Stimulus pushes the expected pulse record; a negedge monitor pops and compares.
module tb_lf_tick_rx;
  import lf_tick_rx_pkg::*;

  localparam int RW = 38;

  logic       clk = 1'b0;
  logic       btnC = 1'b1;
  logic       clk_LF = 1'b0;
  logic       tick, tick_fall, period_valid, stalled;
  logic [7:0] period;
  logic [7:0] tick_cnt;
  logic [1:0] state;

  logic [15:0]   cyc = '0;
  logic [RW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;

  // Bench-side expectations
  logic [7:0]  m_tcnt;
  logic [1:0]  m_state;
  logic [7:0]  m_period;
  logic [15:0] m_last;

  lf_tick_rx #(
    .SYNC_STAGES(2),
    .PERIOD_W   (8),
    .TIMEOUT    (100)
  ) dut (
    .clk         (clk),
    .btnC        (btnC),
    .clk_LF      (clk_LF),
    .tick        (tick),
    .tick_fall   (tick_fall),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled),
    .tick_cnt    (tick_cnt),
    .state       (state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (tick || tick_fall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_pulse: got tick=%0b tick_fall=%0b expected none (cycle %0d)",
                 tick, tick_fall, cyc);
      end else begin
        check("pulse_record",
              64'({cyc, tick, tick_fall, period, period_valid, tick_cnt, stalled, state}),
              64'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_tcnt = 8'd0; m_state = ST_INIT; m_period = 8'd0; m_last = 16'd0;
  endtask

  // Change clk_LF just after an edge; the pulse is due 3 edges later.
  task automatic lf_set(input logic v);
    logic [15:0] p;
    @(posedge clk); #1;
    if (v !== clk_LF) begin
      p = cyc + 16'd3;
      if (v) begin
        m_tcnt = m_tcnt + 8'd1;
        if (m_state == ST_ARMED || m_state == ST_LOCKED) begin
          m_period = 8'(p - m_last);
          m_state  = ST_LOCKED;
        end else begin
          m_state = ST_ARMED;
        end
        m_last = p;
      end
      exp_q.push_back({p, v, ~v, m_period, m_state == ST_LOCKED, m_tcnt,
                       m_state == ST_STALL, m_state});
    end
    clk_LF = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, 64'(tick), 64'd0);
    check({tag, "_tick_fall"}, 64'(tick_fall), 64'd0);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_period_valid"}, 64'(period_valid), 64'd0);
    check({tag, "_stalled"}, 64'(stalled), 64'd0);
    check({tag, "_tick_cnt"}, 64'(tick_cnt), 64'd0);
    check({tag, "_state"}, 64'(state), 64'(ST_INIT));
  endtask

  task automatic do_reset(input logic level, input string tag);
    @(posedge clk); #1;
    btnC = 1'b1; clk_LF = level;
    @(posedge clk); #1;
    check_all_zero(tag);
    btnC = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic square(input int n_rises);
    for (int i = 0; i < n_rises; i++) begin
      lf_set(1'b1);
      repeat (9) @(posedge clk);
      lf_set(1'b0);
      repeat (9) @(posedge clk);
    end
  endtask

  initial begin
    model_reset();
    // 1: first rise after reset -> tick 3 edges after first sample, ARMED
    do_reset(1'b0, "rst_low");
    repeat (10) @(posedge clk);
    lf_set(1'b1);
    repeat (5) @(posedge clk);
    lf_set(1'b0);
    drain("first_rise");
    check("first_state", 64'(state), 64'(ST_ARMED));
    check("first_tick_cnt", 64'(tick_cnt), 64'd1);

    // 2: square wave, period 20, three rises
    do_reset(1'b0, "rst_sq");
    repeat (4) @(posedge clk);
    square(3);
    drain("square");
    check("square_period", 64'(period), 64'd20);
    check("square_valid", 64'(period_valid), 64'd1);
    check("square_tick_cnt", 64'(tick_cnt), 64'd3);

    // 3: level high across release -> no tick, next fall gives tick_fall
    do_reset(1'b1, "rst_high");
    repeat (50) @(posedge clk);
    check("high_hold_tick_cnt", 64'(tick_cnt), 64'd0);
    check("high_hold_state", 64'(state), 64'(ST_INIT));
    lf_set(1'b0);
    drain("high_fall");

    // 4: lock, freeze high, stall exactly 100 cycles after the last tick
    do_reset(1'b0, "rst_stall");
    repeat (4) @(posedge clk);
    lf_set(1'b1);
    repeat (9) @(posedge clk);
    lf_set(1'b0);
    repeat (9) @(posedge clk);
    lf_set(1'b1);
    while (cyc < m_last + 16'd99) @(negedge clk);
    check("pre_stall_stalled", 64'(stalled), 64'd0);
    check("pre_stall_valid", 64'(period_valid), 64'd1);
    @(negedge clk);
    check("stall_stalled", 64'(stalled), 64'd1);
    check("stall_valid", 64'(period_valid), 64'd0);
    check("stall_state", 64'(state), 64'(ST_STALL));
    check("stall_period_kept", 64'(period), 64'd20);
    m_state = ST_STALL;
    lf_set(1'b0);
    repeat (9) @(posedge clk);
    lf_set(1'b1);
    repeat (9) @(posedge clk);
    lf_set(1'b0);
    repeat (9) @(posedge clk);
    lf_set(1'b1);
    drain("recover");
    check("recover_state", 64'(state), 64'(ST_LOCKED));

    // 5: 256 rises -> tick_cnt wraps to 0, period stays 20
    do_reset(1'b0, "rst_wrap");
    repeat (4) @(posedge clk);
    square(256);
    drain("wrap");
    check("wrap_tick_cnt", 64'(tick_cnt), 64'd0);
    check("wrap_period", 64'(period), 64'd20);
    check("wrap_state", 64'(state), 64'(ST_LOCKED));

    // 6: one-cycle reset mid-period in LOCKED, rise arrives during warm-up
    @(posedge clk); #1;
    btnC = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    btnC = 1'b0;
    clk_LF = 1'b1;
    model_reset();
    repeat (15) @(posedge clk);
    #1;
    check("midrst_tick_cnt", 64'(tick_cnt), 64'd0);
    check("midrst_state", 64'(state), 64'(ST_INIT));
    check("midrst_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
